alu_sequencer: RTL and testbench

- Front-end controller for the 4-bit board ALU.
- Conditions two raw push-buttons and steps a 4-state machine that captures operand A, operand B and the 6-bit opcode from the switch bank into registers that drive the ALU.
- Latches the ALU's combinational result into a registered LED output with a valid flag.
- Sits between the board I/O (switches, buttons, LEDs) and the `alu` instance in the board top level.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_sequencer_if.sv | 27 ++
 rtl/alu_sequencer_btn_conditioner.sv | 60 ++++++
 rtl/alu_sequencer.sv | 118 +++++++++++
 tb/tb_alu_sequencer.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the board ALU and its front-end sequencer:
// opcode constants, sequencer state encodings and default widths.
package alu_pkg;

  localparam int unsigned NB_DATA = 4;
  localparam int unsigned NB_OP   = 6;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

  typedef enum logic [1:0] {
    S_LOAD_A  = 2'd0,
    S_LOAD_B  = 2'd1,
    S_LOAD_OP = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// Board-side bundle of the ALU sequencer: switches, buttons, ALU result in;
// operands, opcode, LEDs, valid and state out.
interface alu_sequencer_if #(
  parameter int unsigned NB_DATA = 4,
  parameter int unsigned NB_OP   = 6
);
  logic [NB_OP-1:0]   i_sw;
  logic               i_btn_next;
  logic               i_btn_clear;
  logic [NB_DATA-1:0] i_alu_result;
  logic [NB_DATA-1:0] o_datoA;
  logic [NB_DATA-1:0] o_datoB;
  logic [NB_OP-1:0]   o_operation;
  logic [NB_DATA-1:0] o_leds;
  logic               o_valid;
  logic [1:0]         o_state;

  modport master (
    output i_sw, i_btn_next, i_btn_clear, i_alu_result,
    input  o_datoA, o_datoB, o_operation, o_leds, o_valid, o_state
  );

  modport slave (
    input  i_sw, i_btn_next, i_btn_clear, i_alu_result,
    output o_datoA, o_datoB, o_operation, o_leds, o_valid, o_state
  );
endinterface

// File: rtl/alu_sequencer_btn_conditioner.sv
// Raw button -> one registered single-cycle pulse per press.
// Debounce filter present only when ALU_SEQ_DEBOUNCE_EN is defined.
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  logic [1:0] sync_q;
  logic       level;
  logic       level_q;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) sync_q <= '0;
    else          sync_q <= {sync_q[0], i_btn};
  end

`ifdef ALU_SEQ_DEBOUNCE_EN
  localparam int unsigned NB_CNT = $clog2(DEBOUNCE_CYCLES + 1);

  logic [NB_CNT-1:0] cnt_q;
  logic              deb_q;

  // Count consecutive cycles of disagreement; flip once DEBOUNCE_CYCLES is reached.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
      deb_q <= 1'b0;
    end else if (sync_q[1] == deb_q) begin
      cnt_q <= '0;
    end else if (cnt_q == NB_CNT'(DEBOUNCE_CYCLES - 1)) begin
      cnt_q <= '0;
      deb_q <= ~deb_q;
    end else begin
      cnt_q <= cnt_q + NB_CNT'(1);
    end
  end

  assign level = deb_q;
`else
  if (DEBOUNCE_CYCLES == 0) begin : g_filter_bypassed
  end

  assign level = sync_q[1];
`endif

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      level_q <= 1'b0;
      o_pulse <= 1'b0;
    end else begin
      level_q <= level;
      o_pulse <= level & ~level_q;
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Board front-end for the 4-bit ALU: captures A, B and opcode from the switches
// on button presses, then latches the ALU result onto the LEDs. Option: ALU_SEQ_DEBOUNCE_EN.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned NB_DATA         = 4,
  parameter int unsigned NB_OP           = 6,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input logic             clk,
  input logic             i_rst_n,
  alu_sequencer_if.slave  bus
);

  localparam logic [NB_OP-1:0] OP_RESET = NB_OP'(OP_ADD);

  logic next_p;
  logic clear_p;

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_btn   (bus.i_btn_next),
    .o_pulse (next_p)
  );

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_btn   (bus.i_btn_clear),
    .o_pulse (clear_p)
  );

  state_t             state_q,    state_d;
  logic               captured_q, captured_d;
  logic [NB_DATA-1:0] a_q,        a_d;
  logic [NB_DATA-1:0] b_q,        b_d;
  logic [NB_OP-1:0]   op_q,       op_d;
  logic [NB_DATA-1:0] leds_q,     leds_d;
  logic               valid_q,    valid_d;

  // Next-state and next-output logic; clear outranks next.
  always_comb begin
    state_d    = state_q;
    captured_d = captured_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    leds_d     = leds_q;
    valid_d    = valid_q;
    if (clear_p) begin
      state_d    = S_LOAD_A;
      captured_d = 1'b0;
      a_d        = '0;
      b_d        = '0;
      op_d       = OP_RESET;
      leds_d     = '0;
      valid_d    = 1'b0;
    end else begin
      case (state_q)
        S_LOAD_A: if (next_p) begin
          a_d     = bus.i_sw[NB_DATA-1:0];
          state_d = S_LOAD_B;
        end
        S_LOAD_B: if (next_p) begin
          b_d     = bus.i_sw[NB_DATA-1:0];
          state_d = S_LOAD_OP;
        end
        S_LOAD_OP: if (next_p) begin
          op_d       = bus.i_sw;
          captured_d = 1'b0;
          state_d    = S_CAPTURE;
        end
        S_CAPTURE: begin
          // First cycle here gives the ALU a full cycle on the new opcode before latching.
          if (next_p) begin
            valid_d    = 1'b0;
            captured_d = 1'b0;
            state_d    = S_LOAD_A;
          end else if (!captured_q) begin
            leds_d     = bus.i_alu_result;
            valid_d    = 1'b1;
            captured_d = 1'b1;
          end
        end
        default: state_d = S_LOAD_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_LOAD_A;
      captured_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= OP_RESET;
      leds_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      captured_q <= captured_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      leds_q     <= leds_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.o_datoA     = a_q;
  assign bus.o_datoB     = b_q;
  assign bus.o_operation = op_q;
  assign bus.o_leds      = leds_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_state     = state_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: vector table, hand-written timing
// corners and randomized presses against a behavioural model.
module tb_alu_sequencer;
  import alu_pkg::*;

  localparam int unsigned NBD = 4;
  localparam int unsigned NBO = 6;
  localparam int unsigned DC  = 16;
`ifdef ALU_SEQ_DEBOUNCE_EN
  localparam int unsigned DBX = DC;
`else
  localparam int unsigned DBX = 0;
`endif
  localparam int unsigned HOLD   = 6 + DBX;
  localparam int unsigned SETTLE = 6 + DBX;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_sequencer_if #(.NB_DATA(NBD), .NB_OP(NBO)) bus ();

  alu_sequencer #(.NB_DATA(NBD), .NB_OP(NBO), .DEBOUNCE_CYCLES(DC)) dut (
    .clk     (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // Stand-in for the board ALU, written from the opcode meanings.
  function automatic logic [3:0] alu_ref(input logic [5:0] op, input logic [3:0] a, input logic [3:0] b);
    int sa;
    case (op)
      OP_ADD: return 4'(int'(a) + int'(b));
      OP_SUB: return 4'(int'(a) - int'(b));
      OP_AND: return a & b;
      OP_OR:  return a | b;
      OP_XOR: return a ^ b;
      OP_NOR: return ~(a | b);
      OP_SRL: return a >> b;
      OP_SRA: begin
        sa = (a >= 4'd8) ? int'(a) - 16 : int'(a);
        return 4'(sa >>> b);
      end
      default: return 4'h0;
    endcase
  endfunction

  assign bus.i_alu_result = alu_ref(bus.o_operation, bus.o_datoA, bus.o_datoB);

  // Behavioural model of the visible registers
  int         ph;
  logic [3:0] ma, mb, ml;
  logic [5:0] mo;
  logic       mv;

  task automatic model_reset();
    ph = 0; ma = 4'h0; mb = 4'h0; mo = OP_ADD; ml = 4'h0; mv = 1'b0;
  endtask

  task automatic model_next(input logic [5:0] sw);
    case (ph)
      0: begin ma = sw[3:0]; ph = 1; end
      1: begin mb = sw[3:0]; ph = 2; end
      2: begin mo = sw; ph = 3; ml = alu_ref(mo, ma, mb); mv = 1'b1; end
      default: begin mv = 1'b0; ph = 0; end
    endcase
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".datoA"},     32'(bus.o_datoA),     32'(ma));
    check({tag, ".datoB"},     32'(bus.o_datoB),     32'(mb));
    check({tag, ".operation"}, 32'(bus.o_operation), 32'(mo));
    check({tag, ".leds"},      32'(bus.o_leds),      32'(ml));
    check({tag, ".valid"},     32'(bus.o_valid),     32'(mv));
    check({tag, ".state"},     32'(bus.o_state),     32'(ph));
  endtask

  task automatic press(input logic nxt, input logic clr, input logic [5:0] sw, input int hold);
    @(negedge clk);
    bus.i_sw        = sw;
    bus.i_btn_next  = nxt;
    bus.i_btn_clear = clr;
    repeat (hold) @(negedge clk);
    bus.i_btn_next  = 1'b0;
    bus.i_btn_clear = 1'b0;
    repeat (SETTLE) @(negedge clk);
  endtask

  typedef struct {
    logic [5:0] sw_a;
    logic [5:0] sw_b;
    logic [5:0] sw_op;
    logic [3:0] exp_leds;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{6'h03, 6'h05, 6'b100000, 4'h8};
    vecs[1] = '{6'h02, 6'h03, 6'b100010, 4'hF};
    vecs[2] = '{6'h3C, 6'h2A, 6'b100100, 4'h8};
    vecs[3] = '{6'h0C, 6'h0A, 6'b100101, 4'hE};
    vecs[4] = '{6'h0C, 6'h0A, 6'b100110, 4'h6};
    vecs[5] = '{6'h08, 6'h01, 6'b000011, 4'hC};
    vecs[6] = '{6'h08, 6'h01, 6'b000010, 4'h4};
    vecs[7] = '{6'h0C, 6'h0A, 6'b100111, 4'h1};
    vecs[8] = '{6'h15, 6'h05, 6'b111111, 4'h0};

    bus.i_sw        = '0;
    bus.i_btn_next  = 1'b0;
    bus.i_btn_clear = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    check_all("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Vector table: full A/B/op/show/return cycle per entry
    for (int i = 0; i < 9; i++) begin
      press(1'b1, 1'b0, vecs[i].sw_a, HOLD);
      model_next(vecs[i].sw_a);
      check($sformatf("vec%0d.datoA", i), 32'(bus.o_datoA), 32'(vecs[i].sw_a[3:0]));
      press(1'b1, 1'b0, vecs[i].sw_b, HOLD);
      model_next(vecs[i].sw_b);
      check($sformatf("vec%0d.datoB", i), 32'(bus.o_datoB), 32'(vecs[i].sw_b[3:0]));
      press(1'b1, 1'b0, vecs[i].sw_op, HOLD);
      model_next(vecs[i].sw_op);
      check($sformatf("vec%0d.op", i),    32'(bus.o_operation), 32'(vecs[i].sw_op));
      check($sformatf("vec%0d.state", i), 32'(bus.o_state),     32'd3);
      check($sformatf("vec%0d.valid", i), 32'(bus.o_valid),     32'd1);
      check($sformatf("vec%0d.leds", i),  32'(bus.o_leds),      32'(vecs[i].exp_leds));
      press(1'b1, 1'b0, 6'h00, HOLD);
      model_next(6'h00);
      check($sformatf("vec%0d.ret_valid", i), 32'(bus.o_valid), 32'd0);
      check($sformatf("vec%0d.ret_state", i), 32'(bus.o_state), 32'd0);
      check($sformatf("vec%0d.ret_leds", i),  32'(bus.o_leds),  32'(vecs[i].exp_leds));
    end

    // Press-to-update latency: pulse after 3+DBX edges, state moves on the next edge
    @(negedge clk);
    bus.i_sw       = 6'h07;
    bus.i_btn_next = 1'b1;
    repeat (3 + DBX) @(posedge clk);
    #1 check("lat.before", 32'(bus.o_state), 32'd0);
    @(posedge clk);
    #1 check("lat.after", 32'(bus.o_state), 32'd1);
    check("lat.datoA", 32'(bus.o_datoA), 32'h7);
    @(negedge clk);
    bus.i_btn_next = 1'b0;
    repeat (SETTLE) @(negedge clk);
    model_next(6'h07);

    // A long hold advances only once
    press(1'b1, 1'b0, 6'h09, 50);
    model_next(6'h09);
    check_all("hold50");

    // Clear and next together in S_LOAD_OP: clear wins
    press(1'b1, 1'b1, 6'h11, HOLD);
    model_reset();
    check_all("clr_next");

    // Opcode lands at edge N, LEDs/valid at edge N+1
    press(1'b1, 1'b0, 6'h06, HOLD); model_next(6'h06);
    press(1'b1, 1'b0, 6'h07, HOLD); model_next(6'h07);
    @(negedge clk);
    bus.i_sw       = OP_XOR;
    bus.i_btn_next = 1'b1;
    repeat (4 + DBX) @(posedge clk);
    #1 check("cap.op_edge", 32'(bus.o_operation), 32'(OP_XOR));
    check("cap.valid_early", 32'(bus.o_valid), 32'd0);
    @(posedge clk);
    #1 check("cap.valid_late", 32'(bus.o_valid), 32'd1);
    check("cap.leds", 32'(bus.o_leds), 32'h1);
    @(negedge clk);
    bus.i_btn_next = 1'b0;
    repeat (SETTLE) @(negedge clk);
    model_next(OP_XOR);
    check_all("cap.settled");
    press(1'b1, 1'b0, 6'h00, HOLD); model_next(6'h00);

    // Randomized presses against the model
    for (int n = 0; n < 60; n++) begin
      int unsigned r;
      logic [5:0]  sw;
      r  = $urandom_range(0, 7);
      sw = 6'($urandom);
      if (r == 7) begin
        press(1'b0, 1'b1, sw, HOLD);
        model_reset();
      end else begin
        if (r == 6 && ph == 2) sw = OP_SUB;
        press(1'b1, 1'b0, sw, HOLD);
        model_next(sw);
      end
      check_all($sformatf("rnd%0d", n));
    end

`ifdef ALU_SEQ_DEBOUNCE_EN
    // Short glitch filtered, real press accepted
    press(1'b1, 1'b0, 6'h0B, 10);
    check_all("glitch10");
    press(1'b1, 1'b0, 6'h0B, 20);
    model_next(6'h0B);
    check_all("press20");
`endif

    // Asynchronous reset mid-cycle while showing a result
    for (int k = 0; k < 4 && ph != 3; k++) begin
      press(1'b1, 1'b0, 6'h2D, HOLD);
      model_next(6'h2D);
    end
    check_all("pre_arst");
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all("arst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_all("post_arst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
